// File: rtl/cossin_arbiter.sv
// rtl/cossin_arbiter.sv - two-requester round-robin arbiter in front of one shared cossin_cordic
//
// Purpose: serialises cos/sin requests from two requesters onto a single
// cossin_cordic instance and returns the result through shared registers.
// Optional feature: define COSSIN_ARB_TIMEOUT_EN to add a WAIT watchdog that
// answers with err=1 and a zero result after TIMEOUT_CYCLES cycles.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   req0/req1           level requests (held until ack is sampled)
//   beta0/beta1         requested angles, Q-format radians
//   ack0/ack1           one-cycle response pulses, never together
//   cos_out/sin_out     shared result registers, hold until next capture
//   err                 watchdog flag, valid with ack (0 without the macro)
//   busy                high while a transaction is in flight
//   cordic_start/_beta  request to the shared cordic
//   cordic_cos/_sin     cordic result, captured when cordic_done is high
//   cordic_done         cordic completion strobe
module cossin_arbiter #(
    parameter int N              = 32,
    parameter int Q              = 16,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [N-1:0] beta0,
    input  logic [N-1:0] beta1,
    output logic         ack0,
    output logic         ack1,
    output logic [N-1:0] cos_out,
    output logic [N-1:0] sin_out,
    output logic         err,
    output logic         busy,
    output logic         cordic_start,
    output logic [N-1:0] cordic_beta,
    input  logic [N-1:0] cordic_cos,
    input  logic [N-1:0] cordic_sin,
    input  logic         cordic_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    if (Q < 0 || Q >= N) begin : g_bad_q
        $error("cossin_arbiter: Q must lie in [0, N-1]");
    end
    // The watchdog counter is 8 bits wide.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("cossin_arbiter: TIMEOUT_CYCLES must lie in [1, 255]");
    end

    logic [1:0]   r_state;
    logic         r_grant;
    logic         r_last_grant;
    logic         r_ack0;
    logic         r_ack1;
    logic         r_busy;
    logic         r_start;
    logic [N-1:0] r_beta;
    logic [N-1:0] r_cos;
    logic [N-1:0] r_sin;
    logic         w_pick;

`ifdef COSSIN_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_cnt;
    logic       r_err;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    // Lone requester wins outright; on contention the one not served last wins.
    assign w_pick = (req0 && req1) ? ~r_last_grant : req1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_busy       <= 1'b0;
            r_start      <= 1'b0;
            r_beta       <= '0;
            r_cos        <= '0;
            r_sin        <= '0;
`ifdef COSSIN_ARB_TIMEOUT_EN
            r_cnt        <= 8'd0;
            r_err        <= 1'b0;
`endif
        end else begin
            // ack/err are single-cycle pulses: raised on entry to RESP only.
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
`ifdef COSSIN_ARB_TIMEOUT_EN
            r_err  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        r_grant <= w_pick;
                        r_beta  <= w_pick ? beta1 : beta0;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_start <= 1'b1;
`ifdef COSSIN_ARB_TIMEOUT_EN
                    r_cnt   <= 8'd0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cordic_done) begin
                        r_cos   <= cordic_cos;
                        r_sin   <= cordic_sin;
                        r_start <= 1'b0;
                        r_ack0  <= ~r_grant;
                        r_ack1  <= r_grant;
                        r_state <= S_RESP;
                    end
`ifdef COSSIN_ARB_TIMEOUT_EN
                    else if (r_cnt == TO_LAST) begin
                        r_cos   <= '0;
                        r_sin   <= '0;
                        r_start <= 1'b0;
                        r_ack0  <= ~r_grant;
                        r_ack1  <= r_grant;
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
`endif
                end
                S_RESP: begin
                    r_last_grant <= r_grant;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_start <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack0         = r_ack0;
    assign ack1         = r_ack1;
    assign busy         = r_busy;
    assign cordic_start = r_start;
    assign cordic_beta  = r_beta;
    assign cos_out      = r_cos;
    assign sin_out      = r_sin;

endmodule

// File: tb/tb_cossin_arbiter.sv
// tb/tb_cossin_arbiter.sv - self-checking bench for cossin_arbiter
module tb_cossin_arbiter;

    localparam int TB_TIMEOUT = 200;
`ifdef COSSIN_ARB_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] beta0 = '0, beta1 = '0;
    logic        ack0, ack1, err, busy, cordic_start, cordic_done;
    logic [31:0] cos_out, sin_out, cordic_beta, cordic_cos, cordic_sin;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    bit c_stall = 1'b0;
    int c_cnt;

    cossin_arbiter #(.N(32), .Q(16), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .beta0(beta0), .beta1(beta1),
        .ack0(ack0), .ack1(ack1), .cos_out(cos_out), .sin_out(sin_out),
        .err(err), .busy(busy),
        .cordic_start(cordic_start), .cordic_beta(cordic_beta),
        .cordic_cos(cordic_cos), .cordic_sin(cordic_sin), .cordic_done(cordic_done)
    );

    always #5 clk = ~clk;

    // Stand-in cordic: an easily invertible mapping, exact for beta=0.
    function automatic logic [31:0] f_cos(input logic [31:0] b);
        return b ^ 32'h0001_0000;
    endfunction
    function automatic logic [31:0] f_sin(input logic [31:0] b);
        return {b[15:0], b[31:16]};
    endfunction

    assign cordic_cos = f_cos(cordic_beta);
    assign cordic_sin = f_sin(cordic_beta);

    // done pulses once after start has been high for 20 cycles
    always @(posedge clk or negedge rst) begin
        if (!rst || !cordic_start) begin
            c_cnt       <= 0;
            cordic_done <= 1'b0;
        end else if (cordic_done) begin
            cordic_done <= 1'b0;
        end else if (c_cnt == 19) begin
            cordic_done <= !c_stall;
        end else begin
            c_cnt <= c_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level reference: one service in flight at a time, timed
    // from the grant edge and the observed cordic_done strobe.
    bit          m_active, m_resp, m_last;
    bit          m_g;
    logic [31:0] m_beta;
    int          m_age, m_wait;
    logic        exp_ack0, exp_ack1, exp_err, exp_busy, exp_start;
    logic [31:0] exp_beta, exp_cos, exp_sin;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_active = 0; m_resp = 0; m_last = 1; m_g = 0;
                exp_ack0 = 0; exp_ack1 = 0; exp_err = 0; exp_busy = 0; exp_start = 0;
                exp_beta = '0; exp_cos = '0; exp_sin = '0;
            end else begin
                exp_ack0 = 0; exp_ack1 = 0; exp_err = 0;
                if (!m_active) begin
                    if (req0 || req1) begin
                        if (req0 && req1) m_g = (m_last == 1'b0);
                        else              m_g = req1;
                        m_beta   = m_g ? beta1 : beta0;
                        m_active = 1; m_resp = 0; m_age = 0;
                        exp_busy = 1; exp_beta = m_beta;
                    end
                end else if (m_resp) begin
                    m_last = m_g; m_active = 0; exp_busy = 0;
                end else begin
                    m_age++;
                    if (m_age == 1) begin
                        exp_start = 1; m_wait = 0;
                    end else begin
                        m_wait++;
                        if (cordic_done || (TO_ON && m_wait == TB_TIMEOUT)) begin
                            exp_cos  = cordic_done ? f_cos(m_beta) : 32'h0;
                            exp_sin  = cordic_done ? f_sin(m_beta) : 32'h0;
                            exp_err  = !cordic_done;
                            exp_start = 0;
                            exp_ack0 = !m_g; exp_ack1 = m_g;
                            m_resp = 1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("ack0", {31'b0, ack0}, {31'b0, exp_ack0});
                check("ack1", {31'b0, ack1}, {31'b0, exp_ack1});
                check("ack_both", {31'b0, ack0 & ack1}, 32'h0);
                check("err", {31'b0, err}, {31'b0, exp_err});
                check("busy", {31'b0, busy}, {31'b0, exp_busy});
                check("cordic_start", {31'b0, cordic_start}, {31'b0, exp_start});
                check("cordic_beta", cordic_beta, exp_beta);
                check("cos_out", cos_out, exp_cos);
                check("sin_out", sin_out, exp_sin);
            end
        end
    end

    task automatic wait_ack(input int limit, output int who);
        who = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                who = ack1 ? 1 : 0;
                if (ack0) req0 = 1'b0;
                if (ack1) req1 = 1'b0;
                break;
            end
        end
        n_tests++;
        if (who < 0) begin
            n_fail++;
            $display("FAIL wait_ack: no ack within %0d cycles", limit);
        end
    endtask

    task automatic wait_start(input int limit);
        bit seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            seen = cordic_start;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL wait_start: cordic_start not seen within %0d cycles", limit);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); #2 rst = 1'b0;
        @(negedge clk); #2 rst = 1'b1;
    endtask

    initial begin
        int who;
        int n;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_start", {31'b0, cordic_start}, 32'h0);
        check("rst_cos", cos_out, 32'h0);
        @(negedge clk); #2 rst = 1'b1;

        // single request, beta = 0
        @(negedge clk); beta0 = 32'h0; req0 = 1'b1;
        wait_ack(100, who);
        check("t1_grantee", who, 32'd0);
        check("t1_cos", cos_out, 32'h0001_0000);
        check("t1_sin", sin_out, 32'h0);
        check("t1_model_cos", exp_cos, 32'h0001_0000);
        @(negedge clk);
        check("t1_busy_after", {31'b0, busy}, 32'h0);

        // simultaneous requests right after reset: 0 first, then 1
        pulse_reset();
        @(negedge clk);
        beta0 = 32'h0000_1111; beta1 = 32'h0000_8000; req0 = 1'b1; req1 = 1'b1;
        wait_ack(100, who);
        check("t2_first", who, 32'd0);
        @(negedge clk); @(negedge clk);
        check("t2_beta1", cordic_beta, 32'h0000_8000);
        wait_ack(100, who);
        check("t2_second", who, 32'd1);
        check("t2_cos", cos_out, 32'h0001_8000);
        check("t2_sin", sin_out, 32'h8000_0000);

        // req0 re-requests at once while req1 stays pending: 0,1,0
        @(negedge clk); req0 = 1'b1; req1 = 1'b1;
        wait_ack(100, who);
        check("t3_g0", who, 32'd0);
        @(negedge clk); req0 = 1'b1;
        wait_ack(100, who);
        check("t3_g1", who, 32'd1);
        wait_ack(100, who);
        check("t3_g2", who, 32'd0);

        // reset at WAIT cycle 10 drops the transaction
        @(negedge clk); beta0 = 32'h0000_4000; req0 = 1'b1;
        wait_start(20);
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("t4_start", {31'b0, cordic_start}, 32'h0);
        check("t4_busy", {31'b0, busy}, 32'h0);
        check("t4_ack", {30'b0, ack1, ack0}, 32'h0);
        check("t4_cos", cos_out, 32'h0);
        check("t4_sin", sin_out, 32'h0);
        @(negedge clk); #2 rst = 1'b1;
        wait_ack(100, who);
        check("t4_reserve", who, 32'd0);
        check("t4_cos2", cos_out, 32'h0001_4000);

        // beta0 changed during WAIT is ignored
        @(negedge clk); beta0 = 32'h0001_2345; req0 = 1'b1;
        wait_start(20);
        beta0 = 32'hFFFF_0000;
        wait_ack(100, who);
        check("t5_cos", cos_out, 32'h0000_2345);
        check("t5_sin", sin_out, 32'h2345_0001);

`ifdef COSSIN_ARB_TIMEOUT_EN
        // watchdog: no done at all
        @(negedge clk); c_stall = 1'b1; beta0 = 32'h0000_0777; req0 = 1'b1;
        wait_start(20);
        n = 0;
        while (!ack0 && !ack1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("t6_cycles", n, 32'd200);
        check("t6_ack0", {31'b0, ack0}, 32'h1);
        check("t6_err", {31'b0, err}, 32'h1);
        check("t6_cos", cos_out, 32'h0);
        check("t6_sin", sin_out, 32'h0);
        req0 = 1'b0;
        @(negedge clk); c_stall = 1'b0;
`endif

        // randomized traffic against the model
        n = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (ack0) req0 = 1'b0;
            else if (!req0 && $urandom_range(0, 3) == 0) begin
                req0 = 1'b1; beta0 = $urandom;
            end
            if (ack1) req1 = 1'b0;
            else if (!req1 && $urandom_range(0, 3) == 0) begin
                req1 = 1'b1; beta1 = $urandom;
            end
            if (ack0 || ack1) n++;
            if ($urandom_range(0, 799) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk); #2 rst = 1'b1;
            end
        end
        check("rand_acks_seen", {31'b0, n > 20}, 32'h1);

        req0 = 1'b0; req1 = 1'b0;
        repeat (60) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cossin_arbiter.md
COSSIN_ARBITER -- requirements
Module: cossin_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, total fixed-point word width (1 sign, 15 integer, 16 fraction).
REQ-002 SHALL have parameter Q, default 16, fraction bits.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 200, maximum WAIT cycles when the timeout feature is compiled in.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have ports req0, req1, input, 1 each, level request from requesters 0 and 1.
REQ-007 SHALL have ports beta0, beta1, input, N each, requested angle in radians.
REQ-008 SHALL have ports ack0, ack1, output, 1 each, one-cycle response pulse.
REQ-009 SHALL have ports cos_out, sin_out, output, N each, shared result registers.
REQ-010 SHALL have port err, output, 1, timeout flag, valid with ack.
REQ-011 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-012 SHALL have ports cordic_start (output, 1), cordic_beta (output, N), cordic_cos and cordic_sin (input, N each), cordic_done (input, 1), connecting to the single shared cossin_cordic.

Function
REQ-013 SHALL implement states IDLE, ISSUE, WAIT, RESP; any illegal encoding SHALL go to IDLE.
REQ-014 IDLE: if any req is high, SHALL select a grantee, latch its beta into cordic_beta and its index into grant, then go to ISSUE; otherwise SHALL stay in IDLE.
REQ-015 Selection: a single requester SHALL be granted directly; when both req0 and req1 are high, the one not equal to last_grant SHALL win (round-robin).
REQ-016 ISSUE: SHALL set cordic_start=1 and go to WAIT.
REQ-017 WAIT: SHALL hold cordic_start=1 while cordic_done=0; on cordic_done=1, SHALL capture cordic_cos/cordic_sin into cos_out/sin_out, clear cordic_start and go to RESP.
REQ-018 RESP: SHALL assert ack of the grantee for exactly one cycle, set last_grant=grant and return to IDLE.
REQ-019 All outputs SHALL be registered; ack0 and ack1 SHALL never be high in the same cycle.
REQ-020 Latency: req high in IDLE at edge E means cordic_start is high after E+1; ack is high in the cycle after the edge at which cordic_done is sampled.
REQ-021 Changes to beta or req of the grantee after latching SHALL be ignored until RESP.
REQ-022 Requester protocol: a requester SHALL hold req and beta stable until it samples ack, and SHALL drop req at that same edge.
REQ-023 cos_out/sin_out SHALL hold their values until the next capture.
REQ-024 err SHALL be 0 except as defined in REQ-029.

Reset
REQ-025 rst low SHALL force IDLE immediately, including mid-WAIT.
REQ-026 Reset SHALL clear ack0, ack1, err, busy, cordic_start, cordic_beta, cos_out and sin_out to 0, clear grant to 0, and set last_grant to 1.
REQ-027 A transaction interrupted by reset SHALL be dropped with no ack; the requester re-requests.

Configuration
REQ-028 Macro COSSIN_ARB_TIMEOUT_EN SHALL gate the WAIT watchdog.
REQ-029 With the macro defined: an 8-bit counter SHALL clear on entry to WAIT; if it reaches TIMEOUT_CYCLES with no cordic_done, the block SHALL drop cordic_start, load cos_out=sin_out=0, and go to RESP, where ack and err pulse together for one cycle.
REQ-030 Without the macro: no counter SHALL exist, err SHALL be tied to 0, and WAIT SHALL wait indefinitely.

Verification (cordic model: done after 20 cycles)
REQ-031 Bench SHALL drive req0 with beta0=32'h0 -> one ack0 pulse with cos_out=32'h00010000 and sin_out=32'h0; busy low afterwards.
REQ-032 Bench SHALL raise req0 and req1 together right after reset -> ack0 first, then ack1; cordic_beta equals beta1 during the second service.
REQ-033 Bench SHALL have req0 re-request immediately while req1 stays pending -> grants alternate 0,1,0.
REQ-034 Bench SHALL assert rst for 1 cycle at WAIT cycle 10 -> no ack; cordic_start=0, outputs 0; the next req is served normally.
REQ-035 Bench SHALL change beta0 while in WAIT -> result corresponds to the latched beta0.
REQ-036 With COSSIN_ARB_TIMEOUT_EN defined and cordic_done held 0, bench SHALL expect ack0 and err high together 200 cycles after WAIT entry, with cos_out=sin_out=0.
